// File: rtl/traffic_light_monitor.sv
// traffic_light_monitor: passive checker for a two-direction traffic signal.
// Define TLM_TIMING_CHECK_EN to enable the yellow/green dwell checks (err_flags[4:3]).
module traffic_light_monitor #(
  parameter int YELLOW_CYCLES = 3,
  parameter int GREEN_MIN     = 5,
  parameter int GREEN_MAX     = 20
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  NS,
  input  logic [2:0]  EW,
  input  logic        clear_err,
  output logic [4:0]  err_flags,
  output logic        err_pulse,
  output logic [15:0] phase_count
);
  typedef enum logic [1:0] {RED, YEL, GRN, UNK} lamp_t;
  function automatic lamp_t decode(input logic [2:0] c);
    return c == 3'b100 ? RED : c == 3'b010 ? YEL : c == 3'b001 ? GRN : UNK;
  endfunction
  function automatic logic legal_step(input lamp_t a, input lamp_t b);
    return a == UNK || b == UNK || a == b || (a == RED && b == GRN) ||
           (a == GRN && b == YEL) || (a == YEL && b == RED);
  endfunction
  // Inputs are registered first, so each check resolves one clock after its sample.
  logic [2:0]  ns_smp_q, ew_smp_q;
  logic        vld_q;
  lamp_t       ns_st_q, ew_st_q, ns_st_d, ew_st_d, ns_nx, ew_nx;
  logic [4:0]  flags_q, flags_d;
  logic        pulse_q;
  logic [15:0] phase_q, phase_d;
  logic [16:0] phase_sum;
  logic [2:0]  base_viol;
  logic [1:0]  tviol;
  logic        ns_gy, ew_gy;
  always_comb begin
    ns_nx = decode(ns_smp_q);
    ew_nx = decode(ew_smp_q);
    ns_gy = vld_q && ns_st_q == GRN && ns_nx == YEL;
    ew_gy = vld_q && ew_st_q == GRN && ew_nx == YEL;
    base_viol[0] = vld_q && (!$onehot(ns_smp_q) || !$onehot(ew_smp_q));
    base_viol[1] = vld_q && ns_smp_q != 3'b100 && ew_smp_q != 3'b100;
    base_viol[2] = vld_q && (!legal_step(ns_st_q, ns_nx) || !legal_step(ew_st_q, ew_nx));
    phase_sum = {1'b0, phase_q} + 17'(ns_gy) + 17'(ew_gy);
    phase_d = phase_sum[16] ? 16'hFFFF : phase_sum[15:0];
    flags_d = (clear_err ? 5'b0 : flags_q) | {tviol, base_viol};
    ns_st_d = vld_q ? ns_nx : ns_st_q;
    ew_st_d = vld_q ? ew_nx : ew_st_q;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      ns_smp_q <= '0;
      ew_smp_q <= '0;
      vld_q    <= 1'b0;
      ns_st_q  <= UNK;
      ew_st_q  <= UNK;
      flags_q  <= '0;
      pulse_q  <= 1'b0;
      phase_q  <= '0;
    end else begin
      ns_smp_q <= NS;
      ew_smp_q <= EW;
      vld_q    <= 1'b1;
      ns_st_q  <= ns_st_d;
      ew_st_q  <= ew_st_d;
      flags_q  <= flags_d;
      pulse_q  <= |{tviol, base_viol};
      phase_q  <= phase_d;
    end
`ifdef TLM_TIMING_CHECK_EN
  logic [7:0] ns_dw_q, ew_dw_q, ns_dw_d, ew_dw_d;
  function automatic logic [7:0] dwell_next(input lamp_t a, input lamp_t b, input logic [7:0] d);
    return a != b ? 8'd1 : d == 8'hFF ? d : d + 8'd1;
  endfunction
  // Overlong green matches a single dwell value, so it fires once per phase.
  function automatic logic [1:0] tchk(input lamp_t a, input lamp_t b, input logic [7:0] d);
    return {a == GRN && ((b == YEL && d < 8'(GREEN_MIN)) || (b == GRN && d == 8'(GREEN_MAX))),
            a == YEL && b == RED && d != 8'(YELLOW_CYCLES)};
  endfunction
  always_comb begin
    ns_dw_d = vld_q ? dwell_next(ns_st_q, ns_nx, ns_dw_q) : ns_dw_q;
    ew_dw_d = vld_q ? dwell_next(ew_st_q, ew_nx, ew_dw_q) : ew_dw_q;
    tviol = vld_q ? tchk(ns_st_q, ns_nx, ns_dw_q) | tchk(ew_st_q, ew_nx, ew_dw_q) : 2'b0;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      ns_dw_q <= '0;
      ew_dw_q <= '0;
    end else begin
      ns_dw_q <= ns_dw_d;
      ew_dw_q <= ew_dw_d;
    end
`else
  assign tviol = 2'b0;
`endif
  assign err_flags   = flags_q;
  assign err_pulse   = pulse_q;
  assign phase_count = phase_q;
endmodule

// File: tb/tb_traffic_light_monitor.sv
// tb_traffic_light_monitor: scoreboard bench; expected violations are queued per sample
// and compared one clock later against err_flags/err_pulse/phase_count.
module tb_traffic_light_monitor;
  localparam logic [2:0] R = 3'b100, Y = 3'b010, G = 3'b001;
`ifdef TLM_TIMING_CHECK_EN
  localparam logic TE = 1'b1;
`else
  localparam logic TE = 1'b0;
`endif
  localparam logic [4:0] ILL = 5'b00001, CON = 5'b00010, SEQ = 5'b00100;
  localparam logic [4:0] YT = {1'b0, TE, 3'b0}, GT = {TE, 4'b0};
  logic clk = 1'b0, reset_n = 1'b0, clear_err = 1'b0;
  logic [2:0] NS = 3'b100, EW = 3'b100;
  logic [4:0] err_flags;
  logic err_pulse;
  logic [15:0] phase_count;
  int checks = 0, errors = 0;
  typedef struct packed {logic [4:0] v; logic [1:0] inc;} exp_t;
  typedef struct packed {logic [2:0] ns; logic [2:0] ew; logic clr; logic [7:0] n; logic [4:0] v; logic [1:0] inc;} seg_t;
  exp_t q[$];
  seg_t segs[$];
  logic [4:0] eflags = '0;
  logic [15:0] ephase = '0;
  traffic_light_monitor dut (
    .clk(clk), .reset_n(reset_n), .NS(NS), .EW(EW), .clear_err(clear_err),
    .err_flags(err_flags), .err_pulse(err_pulse), .phase_count(phase_count)
  );
  always #5 clk = ~clk;
  task automatic add(input logic [2:0] ns, input logic [2:0] ew, input logic clr,
                     input logic [7:0] n, input logic [4:0] v, input logic [1:0] inc);
    segs.push_back({ns, ew, clr, n, v, inc});
  endtask
  // One clock of stimulus; returns the expectation for the sample taken one clock earlier.
  task automatic step(input logic [2:0] ns, input logic [2:0] ew, input logic clr,
                      input logic [4:0] v, input logic [1:0] inc,
                      output logic chk, output logic [4:0] ef, output logic ep, output logic [15:0] ph);
    exp_t e;
    NS = ns;
    EW = ew;
    clear_err = clr;
    q.push_back('{v: v, inc: inc});
    @(posedge clk);
    #1;
    chk = q.size() > 1;
    ep = 1'b0;
    if (chk) begin
      e = q.pop_front();
      eflags = (clr ? 5'b0 : eflags) | e.v;
      ephase = ephase + 16'(e.inc);
      ep = |e.v;
    end
    ef = eflags;
    ph = ephase;
  endtask
  task automatic restart_model();
    q.delete();
    eflags = '0;
    ephase = '0;
  endtask
  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({err_flags, err_pulse, phase_count} !== 22'b0) begin
      errors++;
      $display("FAIL reset: flags=%b pulse=%b phase=%0d, expected all zero", err_flags, err_pulse, phase_count);
    end
    reset_n = 1'b1;
    restart_model();
  endtask
  task automatic test_legal();
    seg_t s; logic chk, ep; logic [4:0] ef; logic [15:0] ph;
    add(G, R, 0, 8, 0, 0); add(Y, R, 0, 3, 0, 1); add(R, R, 0, 2, 0, 0);
    add(R, G, 0, 8, 0, 0); add(R, Y, 0, 3, 0, 1); add(R, R, 0, 2, 0, 0);
    while (segs.size() > 0) begin
      s = segs.pop_front();
      for (int j = 0; j < int'(s.n); j++) begin
        step(s.ns, s.ew, s.clr, j == 0 ? s.v : 5'b0, j == 0 ? s.inc : 2'b0, chk, ef, ep, ph);
        if (chk) begin
          checks++;
          if ({err_flags, err_pulse, phase_count} !== {ef, ep, ph}) begin
            errors++;
            $display("FAIL legal: flags=%b pulse=%b phase=%0d, expected flags=%b pulse=%b phase=%0d",
                     err_flags, err_pulse, phase_count, ef, ep, ph);
          end
        end
      end
    end
  endtask
  task automatic test_conflict();
    seg_t s; logic chk, ep; logic [4:0] ef; logic [15:0] ph;
    add(G, R, 0, 8, 0, 0); add(Y, R, 0, 2, 0, 1); add(Y, G, 0, 1, CON, 0); add(R, G, 0, 1, 0, 0);
    add(R, G, 0, 7, 0, 0); add(R, Y, 0, 3, 0, 1); add(R, R, 0, 2, 0, 0);
    add(R, R, 1, 1, 0, 0);
    add(G, R, 0, 8, 0, 0); add(Y, R, 0, 2, 0, 1); add(Y, G, 1, 1, CON, 0); add(R, G, 1, 1, 0, 0);
    add(R, G, 0, 7, 0, 0); add(R, Y, 0, 3, 0, 1); add(R, R, 0, 2, 0, 0);
    while (segs.size() > 0) begin
      s = segs.pop_front();
      for (int j = 0; j < int'(s.n); j++) begin
        step(s.ns, s.ew, s.clr, j == 0 ? s.v : 5'b0, j == 0 ? s.inc : 2'b0, chk, ef, ep, ph);
        if (chk) begin
          checks++;
          if ({err_flags, err_pulse, phase_count} !== {ef, ep, ph}) begin
            errors++;
            $display("FAIL conflict/clear: flags=%b pulse=%b phase=%0d, expected flags=%b pulse=%b phase=%0d",
                     err_flags, err_pulse, phase_count, ef, ep, ph);
          end
        end
      end
    end
  endtask
  task automatic test_sequence();
    seg_t s; logic chk, ep; logic [4:0] ef; logic [15:0] ph;
    add(G, R, 0, 8, 0, 0); add(R, R, 0, 1, SEQ, 0); add(3'b011, R, 0, 1, ILL, 0); add(R, R, 0, 2, 0, 0);
    add(R, 3'b000, 0, 1, ILL, 0); add(R, R, 0, 2, 0, 0); add(3'b110, G, 0, 1, ILL | CON, 0);
    add(R, G, 0, 8, 0, 0); add(R, Y, 0, 3, 0, 1); add(R, R, 0, 2, 0, 0);
    while (segs.size() > 0) begin
      s = segs.pop_front();
      for (int j = 0; j < int'(s.n); j++) begin
        step(s.ns, s.ew, s.clr, j == 0 ? s.v : 5'b0, j == 0 ? s.inc : 2'b0, chk, ef, ep, ph);
        if (chk) begin
          checks++;
          if ({err_flags, err_pulse, phase_count} !== {ef, ep, ph}) begin
            errors++;
            $display("FAIL sequence: flags=%b pulse=%b phase=%0d, expected flags=%b pulse=%b phase=%0d",
                     err_flags, err_pulse, phase_count, ef, ep, ph);
          end
        end
      end
    end
  endtask
  task automatic test_timing();
    seg_t s; logic chk, ep; logic [4:0] ef; logic [15:0] ph;
    add(R, R, 1, 1, 0, 0);
    add(G, R, 0, 8, 0, 0); add(Y, R, 0, 2, 0, 1); add(R, R, 0, 1, YT, 0); add(R, R, 0, 1, 0, 0);
    add(G, R, 0, 20, 0, 0); add(G, R, 0, 1, GT, 0); add(G, R, 0, 5, 0, 0);
    add(Y, R, 0, 3, 0, 1); add(R, R, 0, 2, 0, 0);
    add(G, R, 0, 4, 0, 0); add(Y, R, 0, 3, GT, 1); add(R, R, 0, 2, 0, 0);
    add(G, R, 0, 5, 0, 0); add(Y, R, 0, 4, 0, 1); add(R, R, 0, 2, YT, 0);
    add(R, G, 0, 20, 0, 0); add(R, Y, 0, 3, 0, 1); add(R, R, 0, 2, 0, 0);
    while (segs.size() > 0) begin
      s = segs.pop_front();
      for (int j = 0; j < int'(s.n); j++) begin
        step(s.ns, s.ew, s.clr, j == 0 ? s.v : 5'b0, j == 0 ? s.inc : 2'b0, chk, ef, ep, ph);
        if (chk) begin
          checks++;
          if ({err_flags, err_pulse, phase_count} !== {ef, ep, ph}) begin
            errors++;
            $display("FAIL timing: flags=%b pulse=%b phase=%0d, expected flags=%b pulse=%b phase=%0d",
                     err_flags, err_pulse, phase_count, ef, ep, ph);
          end
        end
      end
    end
  endtask
  task automatic test_reset_mid_green();
    seg_t s; logic chk, ep; logic [4:0] ef; logic [15:0] ph;
    add(3'b111, R, 0, 1, ILL, 0); add(G, R, 0, 15, 0, 0);
    while (segs.size() > 0) begin
      s = segs.pop_front();
      for (int j = 0; j < int'(s.n); j++)
        step(s.ns, s.ew, s.clr, j == 0 ? s.v : 5'b0, j == 0 ? s.inc : 2'b0, chk, ef, ep, ph);
    end
    #3 reset_n = 1'b0;
    #1;
    checks++;
    if ({err_flags, err_pulse, phase_count} !== 22'b0) begin
      errors++;
      $display("FAIL reset_mid: flags=%b pulse=%b phase=%0d, expected all zero", err_flags, err_pulse, phase_count);
    end
    @(posedge clk);
    #1 reset_n = 1'b1;
    restart_model();
    add(G, R, 0, 8, 0, 0); add(Y, R, 0, 3, 0, 1); add(R, R, 0, 3, 0, 0);
    while (segs.size() > 0) begin
      s = segs.pop_front();
      for (int j = 0; j < int'(s.n); j++) begin
        step(s.ns, s.ew, s.clr, j == 0 ? s.v : 5'b0, j == 0 ? s.inc : 2'b0, chk, ef, ep, ph);
        if (chk) begin
          checks++;
          if ({err_flags, err_pulse, phase_count} !== {ef, ep, ph}) begin
            errors++;
            $display("FAIL after_reset: flags=%b pulse=%b phase=%0d, expected flags=%b pulse=%b phase=%0d",
                     err_flags, err_pulse, phase_count, ef, ep, ph);
          end
        end
      end
    end
  endtask
  initial begin
    test_reset();
    test_legal();
    test_conflict();
    test_sequence();
    test_timing();
    test_reset_mid_green();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
